param_counter: RTL and testbench
================================

// Module: param_counter
// PURPOSE
//  Parametrised successor to the basic 4-bit enable counter: programmable-width up/down
//  counter with modulo limit, wrap or saturate mode, synchronous load/clear and enable
//  prescaler. Registered terminal-count pulse and sticky overflow/underflow flags.
//  General event/tick counter instantiated by the timer and monitor blocks.
// PARAMETERS
//  WIDTH      8             counter width in bits (>=1)
//  MAX_COUNT  2**WIDTH-1    upper bound; count range 0..MAX_COUNT (MAX_COUNT < 2**WIDTH)
//  SATURATE   0             0 = wrap at bounds, 1 = hold at bounds
//  PRESCALE   1             one count step per PRESCALE enabled cycles (>=1)
// PORTS
//  clock       in   1      rising-edge clock
//  reset       in   1      asynchronous, active-high reset
//  clear       in   1      synchronous clear of count, prescaler and sticky flags
//  load        in   1      synchronous load of load_value
//  load_value  in   WIDTH  value to load; values >MAX_COUNT clamp to MAX_COUNT
//  enable      in   1      advances prescaler; count steps when prescaler expires
//  up_down     in   1      1 = count up, 0 = count down; sampled on the step cycle
//  out         out  WIDTH  current count (registered)
//  terminal    out  1      one-cycle pulse: a step hit a bound (wrap or saturate)
//  overflow    out  1      sticky: an up step occurred at MAX_COUNT
//  underflow   out  1      sticky: a down step occurred at 0
// BEHAVIOUR
//  - reset=1: out=0, terminal=0, overflow=0, underflow=0, prescaler=0, asynchronously.
//    Takes effect immediately without a clock edge; mid-count reset discards all state.
//  - Per-edge priority: clear > load > step > hold.
//  - clear: out=0, prescaler=0, overflow=0, underflow=0, terminal=0.
//  - load: out=min(load_value,MAX_COUNT), prescaler=0, terminal=0; flags unchanged.
//  - Prescaler p in 0..PRESCALE-1. enable=1 and p<PRESCALE-1: p+1, no step.
//    enable=1 and p==PRESCALE-1: p=0 and a step occurs. enable=0: p and out hold.
//    PRESCALE=1: a step occurs on every enabled cycle.
//  - Step up: out<MAX_COUNT -> out+1. out==MAX_COUNT -> SATURATE=0: out=0;
//    SATURATE=1: out holds. Either case: terminal=1, overflow=1.
//  - Step down: out>0 -> out-1. out==0 -> SATURATE=0: out=MAX_COUNT;
//    SATURATE=1: out holds. Either case: terminal=1, underflow=1.
//  - Latency: out and terminal update on the same edge that samples the step condition.
//    terminal is high for exactly that one cycle. With SATURATE=1, every blocked step
//    pulses terminal again.
//  - MAX_COUNT below 2**WIDTH-1 gives modulo-(MAX_COUNT+1) counting. out never exceeds
//    MAX_COUNT. No intermediate arithmetic is wider than WIDTH+1.
//  - clear or load asserted together with enable: the prescaler tick is discarded.
//    up_down may change at any time; only its value on the step cycle matters.
// TESTING
//  1. Count up to 5, then pulse reset between edges -> out=0 immediately; flags stay 0.
//  2. WIDTH=4, wrap, up, enable for 16 cycles from 0 -> out 15->0 on the 16th step;
//     terminal high 1 cycle; overflow=1 until clear.
//  3. MAX_COUNT=9, load 0, up_down=0, one step -> out=9, terminal pulse, underflow=1,
//     overflow=0.
//  4. SATURATE=1, MAX_COUNT=9, up, enable for 12 cycles from 0 -> out holds 9;
//     terminal pulses on each of the 3 blocked steps.
//  5. PRESCALE=3: enable for 9 cycles -> out=3. Drop enable for 4 cycles -> out and
//     prescaler hold. Re-enable -> next step after 3 more cycles.
//  6. clear+load+enable in one cycle -> out=0, flags 0. MAX_COUNT=9, load 12 -> out=9.

Source files
------------

// File: rtl/param_counter.sv
`timescale 1ns/1ps
// Purpose : programmable-width up/down counter with modulo limit, wrap/saturate mode,
//           synchronous clear/load, enable prescaler, terminal pulse and sticky flags.
// Latency : out/terminal/flags update on the same clock edge that samples the step.
// Backpressure: none; every edge is accepted.
// Ports   : clock, reset (async, active-high) | clear, load, load_value, enable, up_down
//           -> out (count), terminal (1-cycle pulse), overflow/underflow (sticky).
module param_counter #(
  parameter int WIDTH     = 8,
  parameter int MAX_COUNT = 2**WIDTH-1,
  parameter bit SATURATE  = 1'b0,
  parameter int PRESCALE  = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             up_down,
  output logic [WIDTH-1:0] out,
  output logic             terminal,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_COUNT);
  // Prescaler needs at least one bit even when PRESCALE==1 (it then stays at 0).
  localparam int               PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    P_LAST = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] out_q, out_d;
  logic [PW-1:0]    p_q, p_d;
  logic             term_q, term_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  always_comb begin
    out_d  = out_q;
    p_d    = p_q;
    term_d = 1'b0;
    ovf_d  = ovf_q;
    unf_d  = unf_q;

    if (clear) begin
      out_d = '0;
      p_d   = '0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else if (load) begin
      // Enable tick in the same cycle is dropped: prescaler restarts from 0.
      out_d = (load_value > MAX_V) ? MAX_V : load_value;
      p_d   = '0;
    end else if (enable) begin
      if (p_q != P_LAST) begin
        p_d = p_q + 1'b1;
      end else begin
        p_d = '0;
        if (up_down) begin
          if (out_q == MAX_V) begin
            term_d = 1'b1;
            ovf_d  = 1'b1;
            out_d  = SATURATE ? out_q : '0;
          end else begin
            out_d = out_q + 1'b1;
          end
        end else begin
          if (out_q == '0) begin
            term_d = 1'b1;
            unf_d  = 1'b1;
            out_d  = SATURATE ? out_q : MAX_V;
          end else begin
            out_d = out_q - 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_q  <= '0;
      p_q    <= '0;
      term_q <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      p_q    <= p_d;
      term_q <= term_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  assign out       = out_q;
  assign terminal  = term_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_param_counter.sv
`timescale 1ns/1ps
module tb_param_counter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_value = '0;
  logic       enable = 1'b0;
  logic       up_down = 1'b0;

  logic [3:0] o0, o1, o2;
  logic       t0, t1, t2, v0, v1, v2, u0f, u1f, u2f;

  always #5 clock = ~clock;

  // u0: plain 4-bit wrap; u1: modulo-10 saturating; u2: modulo-10 wrap, prescale 3
  param_counter #(.WIDTH(4)) u0 (
    .clock(clock), .reset(reset), .clear(clear), .load(load), .load_value(load_value),
    .enable(enable), .up_down(up_down), .out(o0), .terminal(t0), .overflow(v0), .underflow(u0f));
  param_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b1)) u1 (
    .clock(clock), .reset(reset), .clear(clear), .load(load), .load_value(load_value),
    .enable(enable), .up_down(up_down), .out(o1), .terminal(t1), .overflow(v1), .underflow(u1f));
  param_counter #(.WIDTH(4), .MAX_COUNT(9), .PRESCALE(3)) u2 (
    .clock(clock), .reset(reset), .clear(clear), .load(load), .load_value(load_value),
    .enable(enable), .up_down(up_down), .out(o2), .terminal(t2), .overflow(v2), .underflow(u2f));

  typedef struct packed {
    logic [3:0] out;
    logic       term;
    logic       ovf;
    logic       unf;
  } exp_t;
  typedef exp_t [2:0] exp3_t;

  exp3_t sb[$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc_n = 0;

  // Reference model: plain integer arithmetic on the counter rules.
  int mx[3]  = '{15, 9, 9};
  bit sat[3] = '{1'b0, 1'b1, 1'b0};
  int pre[3] = '{1, 1, 3};
  int cnt[3], pcnt[3];
  bit m_term[3], m_ovf[3], m_unf[3];

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      cnt[i] = 0; pcnt[i] = 0; m_term[i] = 0; m_ovf[i] = 0; m_unf[i] = 0;
    end
  endfunction

  function automatic void model_step(int i, bit c, bit l, int lv, bit en, bit ud);
    bit step = 0;
    m_term[i] = 0;
    if (c) begin
      cnt[i] = 0; pcnt[i] = 0; m_ovf[i] = 0; m_unf[i] = 0;
    end else if (l) begin
      cnt[i] = (lv > mx[i]) ? mx[i] : lv;
      pcnt[i] = 0;
    end else if (en) begin
      pcnt[i] = pcnt[i] + 1;
      if (pcnt[i] == pre[i]) begin
        pcnt[i] = 0;
        step = 1;
      end
    end
    if (step) begin
      if (ud) begin
        if (cnt[i] == mx[i]) begin
          m_term[i] = 1; m_ovf[i] = 1;
          if (!sat[i]) cnt[i] = 0;
        end else cnt[i] = cnt[i] + 1;
      end else begin
        if (cnt[i] == 0) begin
          m_term[i] = 1; m_unf[i] = 1;
          if (!sat[i]) cnt[i] = mx[i];
        end else cnt[i] = cnt[i] - 1;
      end
    end
  endfunction

  function automatic exp3_t actual();
    exp3_t a;
    a[0] = '{out: o0, term: t0, ovf: v0, unf: u0f};
    a[1] = '{out: o1, term: t1, ovf: v1, unf: u1f};
    a[2] = '{out: o2, term: t2, ovf: v2, unf: u2f};
    return a;
  endfunction

  task automatic chk(string nm, int inst, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s u%0d cycle %0d: got %0d expected %0d", nm, inst, cyc_n, act, exp);
    end
  endtask

  task automatic cmp3(string tag, exp3_t a, exp3_t e);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_out"},  i, 32'(a[i].out),  32'(e[i].out));
      chk({tag, "_term"}, i, 32'(a[i].term), 32'(e[i].term));
      chk({tag, "_ovf"},  i, 32'(a[i].ovf),  32'(e[i].ovf));
      chk({tag, "_unf"},  i, 32'(a[i].unf),  32'(e[i].unf));
    end
  endtask

  function automatic exp3_t model_view();
    exp3_t e;
    for (int i = 0; i < 3; i++)
      e[i] = '{out: 4'(cnt[i]), term: m_term[i], ovf: m_ovf[i], unf: m_unf[i]};
    return e;
  endfunction

  // One clock cycle of stimulus; expectation queued at the sampling edge.
  task automatic cyc(bit c, bit l, int lv, bit en, bit ud);
    clear = c; load = l; load_value = 4'(lv); enable = en; up_down = ud;
    @(posedge clock);
    for (int i = 0; i < 3; i++) model_step(i, c, l, lv, en, ud);
    sb.push_back(model_view());
    cyc_n++;
    #1;
  endtask

  // Reset pulsed between edges: outputs must clear without any clock edge.
  task automatic async_reset();
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    model_reset();
    cmp3("async_rst", actual(), model_view());
    #1 reset = 1'b0;
  endtask

  // Monitor: every cycle the DUTs present a new registered output set.
  initial begin
    exp3_t e;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp3("cyc", actual(), e);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #12;
    cmp3("reset", actual(), model_view());
    #1 reset = 1'b0;

    repeat (5) cyc(0, 0, 0, 1, 1);          // count up to 5
    async_reset();
    repeat (16) cyc(0, 0, 0, 1, 1);         // u0 wraps 15->0, u1 saturates at 9
    repeat (3) cyc(0, 0, 0, 0, 1);          // hold
    cyc(1, 0, 0, 0, 0);                     // clear flags
    cyc(0, 1, 0, 0, 0);                     // load 0
    repeat (3) cyc(0, 0, 0, 1, 0);          // down step from 0
    cyc(1, 1, 7, 1, 1);                     // clear beats load and enable
    cyc(0, 1, 12, 0, 0);                    // load clamps to MAX_COUNT
    cyc(0, 1, 12, 1, 1);                    // load beats enable
    cyc(1, 0, 0, 0, 0);
    repeat (9) cyc(0, 0, 0, 1, 1);          // prescaled: u2 reaches 3
    repeat (4) cyc(0, 0, 0, 0, 1);          // prescaler holds
    repeat (3) cyc(0, 0, 0, 1, 1);          // next u2 step on third cycle

    for (int k = 0; k < 3000; k++) begin
      bit c, l, en, ud;
      c  = ($urandom_range(0, 99) < 2);
      l  = ($urandom_range(0, 99) < 5);
      en = ($urandom_range(0, 99) < 75);
      ud = ($urandom_range(0, 99) < 60);
      cyc(c, l, $urandom_range(0, 15), en, ud);
      if (k % 700 == 350) async_reset();
    end

    cyc(0, 0, 0, 0, 0);
    repeat (2) @(negedge clock);
    chk("sb_drain", 0, 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
